// File: rtl/zone_seq_tx.sv
// zone_seq_tx: repeating MSB-first serial pattern transmitter.
// Emits L bits of a captured word rptCnt+1 times with a one-bit gap between them.
module zone_seq_tx #(
  parameter int BIT_DIV = 4
) (
  input  logic       clk1,
  input  logic       clear_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] patIn,
  input  logic [2:0] patLen,
  input  logic [3:0] rptCnt,
  output logic       dIout,
  output logic       dSout,
  output logic       busy,
  output logic       done
);

  localparam int CW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(BIT_DIV - 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [2:0]    top;
  logic [3:0]    rep;
  logic [7:0]    pat;
  logic [2:0]    len_m1;

  // patLen 0 means 8 bits, so index of the first bit wraps to 7
  assign len_m1 = patLen - 3'd1;

  // sequencer: all outputs are registered from next-state decisions
  always_ff @(posedge clk1 or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      top   <= '0;
      rep   <= '0;
      pat   <= '0;
      dIout <= 1'b0;
      dSout <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      rep   <= '0;
      dIout <= 1'b0;
      dSout <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done  <= 1'b0;
      dSout <= 1'b0;
      case (state)
        IDLE: begin
          dIout <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            pat   <= patIn;
            top   <= len_m1;
            rep   <= rptCnt;
            bidx  <= len_m1;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
            dIout <= patIn[len_m1];
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bidx != 3'd0) begin
              bidx  <= bidx - 3'd1;
              dIout <= pat[bidx - 3'd1];
            end else if (rep != 4'd0) begin
              rep   <= rep - 4'd1;
              state <= GAP;
              dIout <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              dIout <= 1'b0;
            end
          end else begin
            cnt   <= cnt + 1'b1;
            dSout <= (cnt == PRE);
          end
        end
        GAP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            bidx  <= top;
            state <= SHIFT;
            dIout <= pat[top];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          dIout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zone_seq_tx.sv
// tb_zone_seq_tx: scoreboard bench for zone_seq_tx.
// Expected strobes/done are queued at start and matched on output.
module tb_zone_seq_tx;

  localparam int BD  = 4;
  localparam int BIG = 100000;

  typedef struct {
    bit kind;
    int cyc;
    bit val;
  } ev_t;

  logic       clk1;
  logic       clear_n;
  logic       start;
  logic       abort;
  logic [7:0] patIn;
  logic [2:0] patLen;
  logic [3:0] rptCnt;
  logic       dIout;
  logic       dSout;
  logic       busy;
  logic       done;

  int  cyc;
  int  total;
  int  bad;
  ev_t q[$];

  zone_seq_tx #(.BIT_DIV(BD)) dut (
    .clk1   (clk1),
    .clear_n(clear_n),
    .start  (start),
    .abort  (abort),
    .patIn  (patIn),
    .patLen (patLen),
    .rptCnt (rptCnt),
    .dIout  (dIout),
    .dSout  (dSout),
    .busy   (busy),
    .done   (done)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] p, input logic [2:0] l,
                      input logic [3:0] r, input int stop,
                      input int e);
    int L;
    int off;
    ev_t ev;
    L = (l == 3'd0) ? 8 : int'(l);
    for (int rr = 0; rr <= int'(r); rr++) begin
      for (int b = 0; b < L; b++) begin
        off = rr * (L + 1) * BD + (b + 1) * BD;
        if (off <= stop) begin
          ev.kind = 1'b0;
          ev.cyc  = e + off;
          ev.val  = p[L-1-b];
          q.push_back(ev);
        end
      end
    end
    off = (int'(r) + 1) * L * BD + int'(r) * BD + 1;
    if (off <= stop) begin
      ev.kind = 1'b1;
      ev.cyc  = e + off;
      ev.val  = 1'b0;
      q.push_back(ev);
    end
  endtask

  task automatic go(input logic [7:0] p, input logic [2:0] l,
                    input logic [3:0] r, input int stop,
                    output int e);
    start  = 1'b1;
    patIn  = p;
    patLen = l;
    rptCnt = r;
    e      = cyc;
    push(p, l, r, stop, e);
  endtask

  task automatic wait_cyc(input int e, input int n);
    while (cyc < e + n) @(negedge clk1);
  endtask

  // match every strobe and done pulse against the queued expectation
  always @(negedge clk1) begin : mon
    ev_t ev;
    if (dSout || done) begin
      if (q.size() == 0) begin
        chk("extra_ev", {30'd0, dSout, done}, 32'd0);
      end else begin
        ev = q.pop_front();
        chk("ev_kind", {31'd0, done}, {31'd0, ev.kind});
        chk("ev_cyc", cyc, ev.cyc);
        if (!ev.kind) chk("ev_bit", {31'd0, dIout}, {31'd0, ev.val});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : drv
    int e;
    int e2;
    total   = 0;
    bad     = 0;
    clear_n = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    patIn   = '0;
    patLen  = '0;
    rptCnt  = '0;
    #1 clear_n = 1'b0;
    #2;
    chk("rst_dI", {31'd0, dIout}, 0);
    chk("rst_dS", {31'd0, dSout}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);

    // basic run, start presented at the release edge
    @(negedge clk1);
    clear_n = 1'b1;
    go(8'h05, 3'd3, 4'd0, BIG, e);
    wait_cyc(e, 1);
    start = 1'b0;
    chk("r1_busy_c1", {31'd0, busy}, 1);
    chk("r1_dI_c1", {31'd0, dIout}, 1);
    wait_cyc(e, 6);
    start = 1'b1;
    wait_cyc(e, 7);
    start = 1'b0;
    wait_cyc(e, 12);
    chk("r1_busy_c12", {31'd0, busy}, 1);
    wait_cyc(e, 13);
    chk("r1_busy_c13", {31'd0, busy}, 0);
    chk("r1_done_c13", {31'd0, done}, 1);
    wait_cyc(e, 14);
    chk("r1_done_c14", {31'd0, done}, 0);

    // abort at the edge ending cycle 9
    go(8'h07, 3'd3, 4'd0, 9, e);
    wait_cyc(e, 1);
    start = 1'b0;
    wait_cyc(e, 9);
    abort = 1'b1;
    wait_cyc(e, 10);
    abort = 1'b0;
    chk("ab_busy", {31'd0, busy}, 0);
    chk("ab_dI", {31'd0, dIout}, 0);
    chk("ab_dS", {31'd0, dSout}, 0);
    wait_cyc(e, 30);
    chk("ab_idle", {31'd0, busy}, 0);

    // one repetition with gap
    go(8'h05, 3'd3, 4'd1, BIG, e);
    wait_cyc(e, 1);
    start = 1'b0;
    wait_cyc(e, 14);
    chk("gap_dI", {31'd0, dIout}, 0);
    chk("gap_busy", {31'd0, busy}, 1);
    wait_cyc(e, 17);
    chk("rep_dI_c17", {31'd0, dIout}, 1);
    wait_cyc(e, 30);
    chk("rep_idle", {31'd0, busy}, 0);

    // full 8-bit field
    go(8'hA5, 3'd0, 4'd0, BIG, e);
    wait_cyc(e, 1);
    start = 1'b0;
    wait_cyc(e, 32);
    chk("l8_busy_c32", {31'd0, busy}, 1);
    wait_cyc(e, 34);
    chk("l8_idle", {31'd0, busy}, 0);

    // async clear during cycle 7
    go(8'h07, 3'd3, 4'd0, 7, e);
    wait_cyc(e, 1);
    start = 1'b0;
    wait_cyc(e, 7);
    #1 clear_n = 1'b0;
    #1;
    chk("clr_busy", {31'd0, busy}, 0);
    chk("clr_dI", {31'd0, dIout}, 0);
    chk("clr_dS", {31'd0, dSout}, 0);
    @(negedge clk1);
    clear_n = 1'b1;
    wait_cyc(e, 20);
    chk("clr_after_busy", {31'd0, busy}, 0);
    chk("clr_after_done", {31'd0, done}, 0);

    // start held through done: back-to-back sequences
    go(8'h05, 3'd3, 4'd0, BIG, e);
    e2 = e + 13;
    push(8'h05, 3'd3, 4'd0, BIG, e2);
    wait_cyc(e, 13);
    chk("b2b_done", {31'd0, done}, 1);
    wait_cyc(e, 14);
    start = 1'b0;
    chk("b2b_busy_c14", {31'd0, busy}, 1);
    wait_cyc(e2, 14);
    chk("b2b_idle", {31'd0, busy}, 0);

    // abort wins over start in idle
    start = 1'b1;
    abort = 1'b1;
    patIn = 8'hFF;
    patLen = 3'd2;
    @(negedge clk1);
    chk("ab_st_busy", {31'd0, busy}, 0);
    start = 1'b0;
    abort = 1'b0;
    repeat (10) @(negedge clk1);
    chk("q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
